// File: rtl/framebuffer_pkg.sv
// Shared constants and types for the framebuffer write path.
// Imported by the rectangle-fill walker and the write arbiter.
package framebuffer_pkg;

  localparam int unsigned FB_WIDTH   = 128;
  localparam int unsigned FB_HEIGHT  = 96;
  localparam int unsigned FB_ADDR_W  = 14;
  localparam int unsigned FB_COLOR_W = 3;

  typedef enum logic {
    SrcHost,
    SrcFill
  } grant_src_e;

  typedef enum logic {
    StIdle,
    StRun
  } fill_state_e;

  typedef struct packed {
    logic [6:0]            y;
    logic [6:0]            x;
    logic [FB_COLOR_W-1:0] color;
  } fb_pixel_t;

endpackage

// File: rtl/fill_rect_walker.sv
// Rectangle-fill engine: latches and clips the bounds, then walks the cursor
// row-major, advancing one pixel per grant.
module fill_rect_walker
  import framebuffer_pkg::*;
#(
  parameter int unsigned Height = FB_HEIGHT
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [6:0]            x0,
  input  logic [6:0]            x1,
  input  logic [6:0]            y0,
  input  logic [6:0]            y1,
  input  logic [FB_COLOR_W-1:0] color,
  input  logic                  abort,
  input  logic                  gnt,
  output logic                  req,
  output logic                  busy,
  output logic                  done,
  output logic [FB_ADDR_W-1:0]  pix_addr,
  output logic [FB_COLOR_W-1:0] pix_color
);

  localparam logic [6:0] YMax = 7'(Height - 1);

  fill_state_e state_q, state_d;
  fb_pixel_t   pix_q, pix_d;
  logic [6:0]  x0_q, x0_d, x1_q, x1_d, y1c_q, y1c_d;
  logic        done_q, done_d;
  logic [6:0]  y1c;
  logic        empty;

  assign y1c   = (y1 > YMax) ? YMax : y1;
  assign empty = (x1 < x0) || (y0 > y1c);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1c_d   = y1c_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x0_d        = x0;
          x1_d        = x1;
          y1c_d       = y1c;
          pix_d.x     = x0;
          pix_d.y     = y0;
          pix_d.color = color;
          if (empty) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Abort wins over completion; a same-cycle grant is still written upstream.
        if (abort) begin
          state_d = StIdle;
        end else if (gnt) begin
          if (pix_q.x != x1_q) begin
            pix_d.x = pix_q.x + 7'd1;
          end else if (pix_q.y != y1c_q) begin
            pix_d.x = x0_q;
            pix_d.y = pix_q.y + 7'd1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      pix_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1c_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1c_q   <= y1c_d;
      done_q  <= done_d;
    end
  end

  assign req       = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign pix_addr  = {pix_q.y, pix_q.x};
  assign pix_color = pix_q.color;

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin share of the display write port between the host and the fill
// engine, with a registered write/address/data output stage.
module framebuffer_write_arbiter
  import framebuffer_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       hostValid,
  output logic                       hostReady,
  input  logic [FB_ADDR_W-1:0]       hostAddress,
  input  logic [FB_COLOR_W-1:0]      hostData,
  input  logic                       fillStart,
  input  logic [$clog2(WIDTH)-1:0]   fillX0,
  input  logic [$clog2(WIDTH)-1:0]   fillX1,
  input  logic [6:0]                 fillY0,
  input  logic [6:0]                 fillY1,
  input  logic [FB_COLOR_W-1:0]      fillColor,
  input  logic                       fillAbort,
  output logic                       fillBusy,
  output logic                       fillDone,
  output logic                       write,
  output logic [FB_ADDR_W-1:0]       writeAddress,
  output logic [FB_COLOR_W-1:0]      writeData
);

  logic                  fill_req, fill_gnt, host_gnt;
  logic [FB_ADDR_W-1:0]  fill_addr;
  logic [FB_COLOR_W-1:0] fill_color;
  grant_src_e            last_q, last_d;
  logic                  write_q, write_d;
  logic [FB_ADDR_W-1:0]  addr_q, addr_d;
  logic [FB_COLOR_W-1:0] data_q, data_d;

  fill_rect_walker #(
    .Height (HEIGHT)
  ) u_walker (
    .clk       (clk),
    .resetN    (resetN),
    .start     (fillStart),
    .x0        (fillX0),
    .x1        (fillX1),
    .y0        (fillY0),
    .y1        (fillY1),
    .color     (fillColor),
    .abort     (fillAbort),
    .gnt       (fill_gnt),
    .req       (fill_req),
    .busy      (fillBusy),
    .done      (fillDone),
    .pix_addr  (fill_addr),
    .pix_color (fill_color)
  );

  // Gated by reset so the host sees no grant while the block is held in reset.
  assign host_gnt  = resetN && hostValid && (!fill_req || last_q == SrcFill);
  assign fill_gnt  = fill_req && (!hostValid || last_q == SrcHost);
  assign hostReady = host_gnt;

  always_comb begin
    last_d  = last_q;
    write_d = host_gnt || fill_gnt;
    addr_d  = addr_q;
    data_d  = data_q;
    if (host_gnt) begin
      last_d = SrcHost;
      addr_d = hostAddress;
      data_d = hostData;
    end else if (fill_gnt) begin
      last_d = SrcFill;
      addr_d = fill_addr;
      data_d = fill_color;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_q  <= SrcFill;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign write        = write_q;
  assign writeAddress = addr_q;
  assign writeData    = data_q;

endmodule
